// File: rtl/dfp_line_adapter.sv
// dfp_line_adapter: completes one 256-bit dfp line read/write as a 4-beat 64-bit bmem burst
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   dfp_addr/read/write/wdata      line request from the cache (levels, held until dfp_resp)
//   dfp_rdata, dfp_resp            assembled read line and one-cycle completion pulse
//   bmem_addr/read/write/wdata     burst command, write beats (registered)
//   bmem_ready                     memory accepts command or write beat
//   bmem_raddr/rdata/rvalid        returning read beats, tagged with their line address
module dfp_line_adapter #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0] dfp_rdata,
    output logic                 dfp_resp,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [31:0]          bmem_raddr,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);
    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int CW = $clog2(BEATS);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} state_t;

    state_t               state, next;
    logic [CW-1:0]        cnt;
    logic [LINE_BITS-1:0] line;
    logic                 hit, last, adv, accept;
    logic                 read_d, write_d, resp_d;
    logic                 unused_addr;

    // bmem_addr doubles as the latched line address, so beats are matched against it
    assign unused_addr = &{1'b0, dfp_addr[4:0]};
    assign hit    = bmem_rvalid && bmem_raddr == bmem_addr;
    assign last   = cnt == CW'(BEATS - 1);
    assign accept = state == IDLE && (dfp_read || dfp_write);
    assign adv    = (state == RD_WAIT && hit) || (state == WR_BURST && bmem_ready);

    always_comb begin
        next = state;
        case (state)
            IDLE:     next = dfp_read ? RD_REQ : dfp_write ? WR_BURST : IDLE;
            RD_REQ:   next = bmem_ready ? RD_WAIT : RD_REQ;
            RD_WAIT:  next = hit && last ? RESP : RD_WAIT;
            WR_BURST: next = bmem_ready && last ? RESP : WR_BURST;
            default:  next = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered
    always_comb begin
        read_d  = next == RD_REQ;
        write_d = next == WR_BURST;
        resp_d  = next == RESP;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            line       <= '0;
            dfp_rdata  <= '0;
            dfp_resp   <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            state      <= next;
            bmem_read  <= read_d;
            bmem_write <= write_d;
            dfp_resp   <= resp_d;
            if (accept) begin
                bmem_addr  <= {dfp_addr[31:5], 5'b0};
                line       <= dfp_wdata;
                bmem_wdata <= dfp_wdata[BEAT_BITS-1:0];
                cnt        <= '0;
            end
            if (adv)
                cnt <= cnt + CW'(1);
            if (state == RD_WAIT && hit)
                line[BEAT_BITS*int'(cnt) +: BEAT_BITS] <= bmem_rdata;
            if (state == RD_WAIT && hit && last)
                dfp_rdata <= {bmem_rdata, line[LINE_BITS-BEAT_BITS-1:0]};
            if (state == WR_BURST && bmem_ready && !last)
                bmem_wdata <= line[BEAT_BITS*(int'(cnt)+1) +: BEAT_BITS];
        end
    end
endmodule

// File: tb/tb_dfp_line_adapter.sv
// tb_dfp_line_adapter: directed self-checking bench for dfp_line_adapter
module tb_dfp_line_adapter;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read, dfp_write;
    logic [255:0] dfp_wdata, dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr, bmem_raddr;
    logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [63:0]  bmem_wdata, bmem_rdata;

    int vectors = 0, miscompares = 0;
    int resp_cnt = 0, rd_cyc = 0, addr_err = 0, proto_err = 0;
    int r0, c0, q0;
    logic [31:0] waddr_exp = '0;
    logic [63:0] wq[$];

    localparam logic [63:0] B0 = 64'h1111_1111_1111_1111, B1 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B2 = 64'h3333_3333_3333_3333, B3 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] WA = 64'hAAAA_0000_0000_000A, WB = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] WC = 64'hCCCC_0000_0000_000C, WD = 64'hDDDD_0000_0000_000D;

    dfp_line_adapter dut (
        .clk(clk), .rst(rst), .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp), .bmem_addr(bmem_addr),
        .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
        .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dfp_resp) resp_cnt++;
        if (bmem_read) rd_cyc++;
        if (bmem_write && bmem_ready) wq.push_back(bmem_wdata);
        if (bmem_write && bmem_addr != waddr_exp) addr_err++;
        if (dfp_read && dfp_write) proto_err++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] a, input logic [63:0] d);
        bmem_rvalid = 1'b1;
        bmem_raddr  = a;
        bmem_rdata  = d;
        tick;
        bmem_rvalid = 1'b0;
    endtask

    task automatic wait_resp(input int max);
        int n = 0;
        while (!dfp_resp && n < max) begin
            tick;
            n++;
        end
        chk("resp_seen", {255'b0, dfp_resp}, 256'd1);
    endtask

    initial begin
        rst = 1'b0; dfp_addr = '0; dfp_read = 0; dfp_write = 0; dfp_wdata = '0;
        bmem_ready = 0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 0;
        tick; tick;
        chk("rst_resp", {255'b0, dfp_resp}, 256'd0);
        chk("rst_rdata", dfp_rdata, 256'd0);
        chk("rst_cmd", {254'b0, bmem_read, bmem_write}, 256'd0);
        chk("rst_addr", {224'b0, bmem_addr}, 256'd0);
        chk("rst_wdata", {192'b0, bmem_wdata}, 256'd0);
        rst = 1'b1;
        tick;

        // minimum-latency read, unaligned address
        r0 = resp_cnt; c0 = rd_cyc;
        dfp_read = 1; dfp_addr = 32'h1000_0004; bmem_ready = 1;
        tick;
        chk("rd1_cmd", {255'b0, bmem_read}, 256'd1);
        chk("rd1_addr", {224'b0, bmem_addr}, {224'b0, 32'h1000_0000});
        tick;
        chk("rd1_cmd_drop", {255'b0, bmem_read}, 256'd0);
        beat(32'h1000_0000, B0); beat(32'h1000_0000, B1); beat(32'h1000_0000, B2);
        chk("rd1_no_early_resp", {255'b0, dfp_resp}, 256'd0);
        beat(32'h1000_0000, B3);
        chk("rd1_resp_cycle6", {255'b0, dfp_resp}, 256'd1);
        chk("rd1_rdata", dfp_rdata, {B3, B2, B1, B0});
        tick;
        dfp_read = 0;
        chk("rd1_resp_pulse", {255'b0, dfp_resp}, 256'd0);
        chk("rd1_read_cycles", rd_cyc - c0, 256'd1);
        tick; tick;
        chk("rd1_no_reaccept", {254'b0, bmem_read, dfp_resp}, 256'd0);
        chk("rd1_resp_count", resp_cnt - r0, 256'd1);

        // write with ready low on alternate cycles
        r0 = resp_cnt; q0 = wq.size(); waddr_exp = 32'h2000_0020;
        dfp_write = 1; dfp_addr = 32'h2000_0020; dfp_wdata = {WD, WC, WB, WA}; bmem_ready = 0;
        tick;
        chk("wr_cmd", {255'b0, bmem_write}, 256'd1);
        for (int n = 0; n < 20 && !dfp_resp; n++) begin
            bmem_ready = ~bmem_ready;
            tick;
        end
        chk("wr_resp", {255'b0, dfp_resp}, 256'd1);
        chk("wr_write_drop", {255'b0, bmem_write}, 256'd0);
        chk("wr_beats", wq.size() - q0, 256'd4);
        chk("wr_beatA", {192'b0, wq[q0]}, {192'b0, WA});
        chk("wr_beatB", {192'b0, wq[q0+1]}, {192'b0, WB});
        chk("wr_beatC", {192'b0, wq[q0+2]}, {192'b0, WC});
        chk("wr_beatD", {192'b0, wq[q0+3]}, {192'b0, WD});
        chk("wr_rdata_kept", dfp_rdata, {B3, B2, B1, B0});
        tick;
        dfp_write = 0; bmem_ready = 1;
        tick;
        chk("wr_resp_count", resp_cnt - r0, 256'd1);
        chk("wr_no_reaccept", {255'b0, bmem_write}, 256'd0);

        // read with ready held low, rvalid during RD_REQ must not count
        c0 = rd_cyc;
        dfp_read = 1; dfp_addr = 32'h3000_0040; bmem_ready = 0;
        tick;
        bmem_rvalid = 1; bmem_raddr = 32'h3000_0040; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int n = 0; n < 5; n++) tick;
        chk("rd3_read_held", {255'b0, bmem_read}, 256'd1);
        bmem_rvalid = 0; bmem_ready = 1;
        tick;
        chk("rd3_read_cycles", rd_cyc - c0, 256'd6);
        beat(32'h3000_0040, B3); beat(32'h3000_0040, B2);
        beat(32'h3000_0040, B1); beat(32'h3000_0040, B0);
        wait_resp(4);
        chk("rd3_rdata", dfp_rdata, {B0, B1, B2, B3});
        dfp_read = 0;
        tick;

        // stray rvalid in IDLE, mismatched beat inside RD_WAIT
        beat(32'h4000_0000, 64'h0BAD_0BAD_0BAD_0BAD); beat(32'h4000_0000, 64'h0BAD_0BAD_0BAD_0BAD);
        chk("idle_stray_rdata", dfp_rdata, {B0, B1, B2, B3});
        chk("idle_stray_quiet", {254'b0, dfp_resp, bmem_read}, 256'd0);
        dfp_read = 1; dfp_addr = 32'h4000_001F;
        tick; tick;
        beat(32'h4000_0000, B1);
        beat(32'h5000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        beat(32'h4000_0000, B2); beat(32'h4000_0000, B3); beat(32'h4000_0000, B0);
        wait_resp(4);
        chk("rd4_rdata", dfp_rdata, {B0, B3, B2, B1});
        dfp_read = 0;
        tick;

        // write followed by read presented the cycle after dfp_resp
        r0 = resp_cnt; q0 = wq.size(); waddr_exp = 32'h6000_0000;
        dfp_write = 1; dfp_addr = 32'h6000_0000; dfp_wdata = {WA, WB, WC, WD};
        tick;
        wait_resp(8);
        chk("wr5_beats", wq.size() - q0, 256'd4);
        tick;
        dfp_write = 0; dfp_read = 1; dfp_addr = 32'h7000_0000;
        tick;
        chk("rd5_accept", {255'b0, bmem_read}, 256'd1);
        chk("rd5_addr", {224'b0, bmem_addr}, {224'b0, 32'h7000_0000});
        tick;
        beat(32'h7000_0000, B0); beat(32'h7000_0000, B0);
        beat(32'h7000_0000, B1); beat(32'h7000_0000, B1);
        wait_resp(4);
        chk("rd5_rdata", dfp_rdata, {B1, B1, B0, B0});
        dfp_read = 0;
        tick; tick;
        chk("wr_rd_resp_count", resp_cnt - r0, 256'd2);
        chk("wr5_beats_total", wq.size() - q0, 256'd4);

        // reset in the middle of a write burst
        r0 = resp_cnt; q0 = wq.size(); waddr_exp = 32'h8000_0000;
        dfp_write = 1; dfp_addr = 32'h8000_0000; dfp_wdata = {WD, WC, WB, WA};
        tick; tick; tick;
        rst = 0;
        #1;
        chk("mid_rst_outputs", {250'b0, dfp_resp, bmem_read, bmem_write, 3'b0}, 256'd0);
        chk("mid_rst_addr", {160'b0, bmem_addr, bmem_wdata}, 256'd0);
        chk("mid_rst_rdata", dfp_rdata, 256'd0);
        chk("mid_rst_beats", wq.size() - q0, 256'd2);
        dfp_write = 0; bmem_rvalid = 1; bmem_raddr = 32'h8000_0000; bmem_rdata = B3;
        tick; tick;
        rst = 1;
        tick; tick;
        bmem_rvalid = 0;
        chk("post_rst_quiet", {253'b0, dfp_resp, bmem_read, bmem_write}, 256'd0);
        chk("post_rst_rdata", dfp_rdata, 256'd0);
        chk("post_rst_no_resp", resp_cnt - r0, 256'd0);
        dfp_read = 1; dfp_addr = 32'h9000_0000;
        tick;
        chk("rd6_addr", {224'b0, bmem_addr}, {224'b0, 32'h9000_0000});
        tick;
        beat(32'h9000_0000, B2); beat(32'h9000_0000, B0);
        beat(32'h9000_0000, B3); beat(32'h9000_0000, B1);
        wait_resp(4);
        chk("rd6_rdata", dfp_rdata, {B1, B3, B0, B2});
        dfp_read = 0;
        tick;

        chk("write_addr_stable", addr_err, 256'd0);
        chk("protocol_both_high", proto_err, 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dfp_line_adapter.md
Name: dfp_line_adapter

Overview:
Memory-side responder for the cache downstream-facing port (dfp_*): accepts one 256-bit cacheline read or write request from the data cache and completes it over the 64-bit burst memory interface (bmem_*) as 4 beats. It sits between the dcache instance in the execute stage and the burst memory model/arbiter. It holds one outstanding transaction and never aborts one, including across branch flushes.

Parameters:
LINE_BITS, 256, cacheline width on the dfp side
BEAT_BITS, 64, burst beat width on the bmem side; BEATS = LINE_BITS/BEAT_BITS (4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
dfp_addr  in  32  line address from the cache; bits [4:0] ignored and forced to 0 internally
dfp_read  in  1  line read request; level, held until dfp_resp
dfp_write  in  1  line write request; level, held until dfp_resp
dfp_wdata  in  LINE_BITS  write line; valid while dfp_write is high
dfp_rdata  out  LINE_BITS  read line; valid in the dfp_resp cycle, held until the next read completes
dfp_resp  out  1  one-cycle completion pulse
bmem_addr  out  32  line-aligned burst address
bmem_read  out  1  burst read command, one cycle
bmem_write  out  1  write beat valid
bmem_wdata  out  BEAT_BITS  write beat data
bmem_ready  in  1  memory accepts a command or write beat this cycle
bmem_raddr  in  32  address tag of the returning read beat
bmem_rdata  in  BEAT_BITS  read beat data
bmem_rvalid  in  1  read beat valid

Behaviour:
- All outputs are registered. While rst=0: state=IDLE, beat counter=0, and dfp_resp, dfp_rdata, bmem_read, bmem_write, bmem_addr, bmem_wdata are all 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP.
- IDLE: on dfp_read|dfp_write, latch {dfp_addr[31:5],5'b0} and dfp_wdata, then go to RD_REQ for a read or WR_BURST for a write. If both are high, read takes priority (protocol violation; the bench flags it).
- RD_REQ: bmem_read=1 and bmem_addr=latched address. Stay until bmem_ready=1 in the same cycle, then go to RD_WAIT with beat counter=0. bmem_read is high only while in RD_REQ.
- RD_WAIT: on bmem_rvalid && bmem_raddr==latched address, write bmem_rdata into line[BEAT_BITS*cnt +: BEAT_BITS] and increment cnt. Beats with a mismatched raddr are dropped. After the 4th beat, go to RESP.
- WR_BURST: bmem_write=1, bmem_addr=latched address, bmem_wdata=line[64*cnt +: 64]. cnt advances only on a cycle with bmem_ready=1. After the 4th accepted beat, go to RESP. bmem_write drops to 0 on entry to RESP.
- RESP: dfp_resp=1 for exactly one cycle, then IDLE. For a read, dfp_rdata updates to the assembled line in this cycle. For a write, dfp_rdata keeps its previous value.
- dfp_read/dfp_write are ignored outside IDLE. This includes the RESP cycle, where the cache still holds its request, so there is no double accept. The cache may present a new request in the cycle after dfp_resp, and it is accepted that cycle.
- bmem_rvalid outside RD_WAIT is ignored: no state change, dfp_rdata unchanged.
- Minimum read latency, with ready=1 and beats back-to-back starting the cycle after the command: accept at edge 0, bmem_read in cycle 1, beats in cycles 2-5, dfp_resp in cycle 6.
- Minimum write latency: accept at edge 0, beats in cycles 1-4, dfp_resp in cycle 5.
- Reset asserted mid-transaction clears everything asynchronously. The partial burst is abandoned, and late read beats after reset are ignored in IDLE.

Test Plan:
- Read to addr 0x1000_0004, ready=1, beats 0x11..1,0x22..2,0x33..3,0x44..4 tagged 0x1000_0000 -> bmem_addr=0x1000_0000, a single-cycle bmem_read, dfp_resp 6 cycles after accept, dfp_rdata={0x44..4,0x33..3,0x22..2,0x11..1}.
- Write to 0x2000_0020 with wdata beats A,B,C,D and bmem_ready low on alternate cycles -> exactly 4 accepted beats in order A,B,C,D, bmem_addr=0x2000_0020 throughout, one dfp_resp pulse.
- Read while bmem_ready stays 0 for 5 cycles -> bmem_read held 5+1 cycles, no beats counted; completes normally once ready rises.
- Stray rvalid in IDLE, plus a beat with mismatched raddr inside RD_WAIT -> ignored; the line is assembled only from the 4 matching beats.
- Write immediately followed by a read (request changes the cycle after dfp_resp) -> read accepted that cycle; exactly two dfp_resp pulses in total.
- rst driven low after the 2nd write beat, released, then a fresh read -> outputs 0 during reset, no dfp_resp for the aborted write, and the read completes correctly.
